// File: rtl/spm_ctrl.sv
// ---------------------------------------------------------------------------
// spm_ctrl
//   Sequencer for the 8-bit serial-parallel multiplier (SPM) datapath.
//   A rising edge on the (already synchronised) start input latches both
//   operands. The multiplicand is loaded into the datapath, and the multiplier
//   is streamed LSB-first for 2N cycles. The serial product bits are
//   deserialised, and completion is signalled with a one-cycle done pulse.
//
//   Build option:
//     SPM_CTRL_SIGNED_EN  defined   -> multiplier sign-extended to 2N bits
//                                      (signed product, signed datapath)
//                         undefined -> multiplier zero-extended (unsigned)
//
//   Ports:
//     clk       in   1    clock, all state on rising edge
//     rst       in   1    asynchronous, active-high reset
//     start     in   1    level start request, edge-detected inside
//     a_in      in   N    multiplicand, sampled on accepted start edge
//     b_in      in   N    multiplier, sampled on accepted start edge
//     spm_p     in   1    serial product bit from datapath (valid with spm_en)
//     spm_load  out  1    1-cycle pulse: datapath captures spm_a, clears state
//     spm_a     out  N    registered multiplicand to datapath
//     spm_en    out  1    shift enable to datapath
//     spm_y     out  1    serial multiplier bit, LSB first
//     product   out  2N   last completed product, held until next completion
//     busy      out  1    high in LOAD and SHIFT
//     done      out  1    1-cycle pulse when product updates
// ---------------------------------------------------------------------------
module spm_ctrl #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    input  logic           spm_p,
    output logic           spm_load,
    output logic [N-1:0]   spm_a,
    output logic           spm_en,
    output logic           spm_y,
    output logic [2*N-1:0] product,
    output logic           busy,
    output logic           done
);

    localparam int CNT_W = $clog2(2*N);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic             start_d;
    logic             start_edge;
    logic [2*N-1:0]   y_sr;
    logic [2*N-1:0]   y_ext;
    logic [2*N-1:0]   prod_sr;
    logic [CNT_W-1:0] cnt;

    assign start_edge = start & ~start_d;

`ifdef SPM_CTRL_SIGNED_EN
    assign y_ext = {{N{b_in[N-1]}}, b_in};
`else
    assign y_ext = {{N{1'b0}}, b_in};
`endif

    // Datapath strobes are decoded straight from the state register so the
    // datapath acts on the same edges the controller advances on.
    always_comb begin
        spm_load = (state == S_LOAD);
        spm_en   = (state == S_SHIFT);
        spm_y    = (state == S_SHIFT) & y_sr[0];
        busy     = (state == S_LOAD) | (state == S_SHIFT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            // Held high so a start already asserted through reset is not an edge.
            start_d <= 1'b1;
            spm_a   <= '0;
            y_sr    <= '0;
            prod_sr <= '0;
            cnt     <= '0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            // Tracks start in every state, so edges outside IDLE are consumed
            // and never replayed later.
            start_d <= start;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        spm_a <= a_in;
                        y_sr  <= y_ext;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt   <= '0;
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    y_sr    <= y_sr >> 1;
                    prod_sr <= {spm_p, prod_sr[2*N-1:1]};
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(2*N-1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    product <= prod_sr;
                    done    <= 1'b1;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spm_ctrl
//   Directed bench for spm_ctrl, paired with a bit-serial shift-add datapath
//   model. Expected products and timings are hand-computed constants.
//   Build with SPM_CTRL_SIGNED_EN to exercise the signed build.
// ---------------------------------------------------------------------------
module tb_spm_ctrl;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   a_in;
    logic [N-1:0]   b_in;
    logic           spm_p;
    logic           spm_load;
    logic [N-1:0]   spm_a;
    logic           spm_en;
    logic           spm_y;
    logic [2*N-1:0] product;
    logic           busy;
    logic           done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    spm_ctrl #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .spm_p    (spm_p),
        .spm_load (spm_load),
        .spm_a    (spm_a),
        .spm_en   (spm_en),
        .spm_y    (spm_y),
        .product  (product),
        .busy     (busy),
        .done     (done)
    );

    // Shift-add serial multiplier: each enabled cycle adds y*A to the
    // accumulator, emits bit 0 and shifts right.
    logic [N-1:0] dp_a;
    logic [2*N:0] dp_acc;
    logic [2*N:0] dp_addend;
    logic [2*N:0] dp_sum;

    always_comb begin
`ifdef SPM_CTRL_SIGNED_EN
        dp_addend = spm_y ? {{(N+1){dp_a[N-1]}}, dp_a} : '0;
`else
        dp_addend = spm_y ? {{(N+1){1'b0}}, dp_a} : '0;
`endif
        dp_sum = dp_acc + dp_addend;
    end

    assign spm_p = dp_sum[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_a   <= '0;
            dp_acc <= '0;
        end else if (spm_load) begin
            dp_a   <= spm_a;
            dp_acc <= '0;
        end else if (spm_en) begin
`ifdef SPM_CTRL_SIGNED_EN
            dp_acc <= {dp_sum[2*N], dp_sum[2*N:1]};
`else
            dp_acc <= {1'b0, dp_sum[2*N:1]};
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation for a fixed 30-cycle window. cyc counts edges from
    // the accepting edge (cyc=1 is just after it).
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit hold, input bit glitch,
                         output logic [2*N-1:0] prod, output int done_cyc,
                         output int done_cnt, output int load_cnt,
                         output int en_cnt, output int en_first,
                         output bit held_ok);
        logic [2*N-1:0] old_prod;
        old_prod = product;
        prod     = 'x;
        done_cyc = 0;
        done_cnt = 0;
        load_cnt = 0;
        en_cnt   = 0;
        en_first = 0;
        held_ok  = 1'b1;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            tick();
            if (!hold && cyc == 2) start = 1'b0;
            if (glitch && cyc == 6) start = 1'b1;
            if (glitch && cyc == 7) start = 1'b0;
            if (spm_load === 1'b1) load_cnt++;
            if (spm_en === 1'b1) begin
                en_cnt++;
                if (en_first == 0) en_first = cyc;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = cyc;
                    prod     = product;
                end
            end
            if (done_cnt == 0 && product !== old_prod) held_ok = 1'b0;
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        int busy_seen;
        int done_seen;
        rst   = 1'b1;
        start = 1'b1;
        a_in  = 8'h5A;
        b_in  = 8'hC3;
        repeat (3) tick();
        tests++;
        if ({busy, done, spm_load, spm_en, spm_y} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 00000", {busy, done, spm_load, spm_en, spm_y});
        end
        tests++;
        if (product !== 16'h0000) begin
            fails++;
            $display("FAIL reset_product: got %h want 0000", product);
        end
        tests++;
        if (spm_a !== 8'h00) begin
            fails++;
            $display("FAIL reset_spm_a: got %h want 00", spm_a);
        end
        rst = 1'b0;
        busy_seen = 0;
        done_seen = 0;
        repeat (20) begin
            tick();
            if (busy !== 1'b0) busy_seen++;
            if (done !== 1'b0) done_seen++;
        end
        tests++;
        if (busy_seen != 0) begin
            fails++;
            $display("FAIL start_through_reset_busy: got %0d busy cycles want 0", busy_seen);
        end
        tests++;
        if (done_seen != 0) begin
            fails++;
            $display("FAIL start_through_reset_done: got %0d done cycles want 0", done_seen);
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [2*N-1:0] p;
        int dc, dn, lc, ec, ef;
        bit hk;
        do_op(8'h0D, 8'h0B, 1'b0, 1'b0, p, dc, dn, lc, ec, ef, hk);
        tests++;
        if (lc != 1) begin
            fails++;
            $display("FAIL basic_load_cnt: got %0d want 1", lc);
        end
        tests++;
        if (ef != 2) begin
            fails++;
            $display("FAIL basic_en_first: got %0d want 2", ef);
        end
        tests++;
        if (ec != 16) begin
            fails++;
            $display("FAIL basic_en_cnt: got %0d want 16", ec);
        end
        // Accepting edge k; done and product appear after edge k+2N+2.
        tests++;
        if (dc != 19) begin
            fails++;
            $display("FAIL basic_done_cycle: got %0d want 19", dc);
        end
        tests++;
        if (dn != 1) begin
            fails++;
            $display("FAIL basic_done_cnt: got %0d want 1", dn);
        end
        tests++;
        if (p !== 16'h008F) begin
            fails++;
            $display("FAIL basic_product: got %h want 008f", p);
        end
        tests++;
        if (busy !== 1'b0 || product !== 16'h008F) begin
            fails++;
            $display("FAIL basic_after: got busy=%b product=%h want busy=0 product=008f", busy, product);
        end
    endtask

    task automatic test_operands();
        logic [2*N-1:0] p;
        int dc, dn, lc, ec, ef;
        bit hk;
        do_op(8'hFF, 8'hFF, 1'b0, 1'b0, p, dc, dn, lc, ec, ef, hk);
        tests++;
`ifdef SPM_CTRL_SIGNED_EN
        if (p !== 16'h0001) begin
            fails++;
            $display("FAIL ffxff_product: got %h want 0001", p);
        end
        do_op(8'h80, 8'h7F, 1'b0, 1'b0, p, dc, dn, lc, ec, ef, hk);
        tests++;
        if (p !== 16'hC080) begin
            fails++;
            $display("FAIL 80x7f_product: got %h want c080", p);
        end
`else
        if (p !== 16'hFE01) begin
            fails++;
            $display("FAIL ffxff_product: got %h want fe01", p);
        end
`endif
        do_op(8'h00, 8'hA5, 1'b0, 1'b0, p, dc, dn, lc, ec, ef, hk);
        tests++;
        if (p !== 16'h0000 || dn != 1) begin
            fails++;
            $display("FAIL zero_product: got %h done=%0d want 0000 done=1", p, dn);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*N-1:0] p;
        int dc, dn, lc, ec, ef;
        bit hk;
        do_op(8'h37, 8'h59, 1'b0, 1'b1, p, dc, dn, lc, ec, ef, hk);
        tests++;
        if (dn != 1 || lc != 1) begin
            fails++;
            $display("FAIL midshift_edge: got done=%0d load=%0d want 1 1", dn, lc);
        end
        tests++;
        if (p !== 16'h131F || !hk) begin
            fails++;
            $display("FAIL midshift_product: got %h held=%0d want 131f held=1", p, hk);
        end
        do_op(8'h12, 8'h34, 1'b0, 1'b0, p, dc, dn, lc, ec, ef, hk);
        tests++;
        if (!hk) begin
            fails++;
            $display("FAIL old_product_held: got held=0 want held=1");
        end
        tests++;
        if (p !== 16'h03A8 || dc != 19) begin
            fails++;
            $display("FAIL second_product: got %h at %0d want 03a8 at 19", p, dc);
        end
    endtask

    task automatic test_hold();
        logic [2*N-1:0] p;
        int dc, dn, lc, ec, ef;
        bit hk;
        do_op(8'h03, 8'h05, 1'b1, 1'b0, p, dc, dn, lc, ec, ef, hk);
        tests++;
        if (dn != 1 || lc != 1 || p !== 16'h000F) begin
            fails++;
            $display("FAIL hold_no_retrigger: got done=%0d load=%0d prod=%h want 1 1 000f", dn, lc, p);
        end
    endtask

    task automatic test_reset_mid();
        logic [2*N-1:0] p;
        int dc, dn, lc, ec, ef;
        bit hk;
        int done_seen;
        a_in  = 8'h21;
        b_in  = 8'h43;
        start = 1'b1;
        tick();                  // LOAD
        repeat (5) tick();       // fifth SHIFT cycle
        rst = 1'b1;
        tick();
        tests++;
        if (busy !== 1'b0 || product !== 16'h0000 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: got busy=%b product=%h done=%b want 0 0000 0", busy, product, done);
        end
        rst   = 1'b0;
        start = 1'b0;
        done_seen = 0;
        repeat (20) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) done_seen++;
        end
        tests++;
        if (done_seen != 0) begin
            fails++;
            $display("FAIL reset_mid_quiet: got %0d active cycles want 0", done_seen);
        end
        do_op(8'h21, 8'h43, 1'b0, 1'b0, p, dc, dn, lc, ec, ef, hk);
        tests++;
        if (p !== 16'h08A3 || dc != 19) begin
            fails++;
            $display("FAIL after_reset_product: got %h at %0d want 08a3 at 19", p, dc);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        a_in  = '0;
        b_in  = '0;
        test_reset();
        test_basic();
        test_operands();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
